// File: rtl/fpnew_sdotp_result_buffer_pkg.sv
// Shared types for the SDOTP result buffer: the FP status flag vector
// and a helper that merges two flag sets.
package fpnew_sdotp_result_buffer_pkg;

  localparam int unsigned StatusWidth = 5;

  // IEEE exception flags in the usual {NV,DZ,OF,UF,NX} order.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Flags are sticky, so merging is a plain bitwise OR.
  function automatic status_t merge_status(input status_t a, input status_t b);
    status_t merged;
    merged = status_t'(StatusWidth'(a) | StatusWidth'(b));
    return merged;
  endfunction

endpackage

// File: rtl/fpnew_sdotp_result_buffer.sv
// Output-side FIFO for the SDOTP wrapper. Decouples the dot-product
// pipeline from consumer stalls, keeps sticky status flags over all
// delivered results and folds its own occupancy into the busy signal.
module fpnew_sdotp_result_buffer
  import fpnew_sdotp_result_buffer_pkg::*;
#(
  parameter int unsigned LaneWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter type         TagType   = logic,
  parameter type         AuxType   = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [LaneWidth-1:0] in_result_i,
  input  status_t              in_status_i,
  input  logic                 in_extension_bit_i,
  input  TagType               in_tag_i,
  input  AuxType               in_aux_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_busy_i,
  input  logic                 flush_i,
  input  logic                 clear_status_i,
  output logic [LaneWidth-1:0] result_o,
  output status_t              status_o,
  output logic                 extension_bit_o,
  output TagType               tag_o,
  output AuxType               aux_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output status_t              sticky_status_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

  // One buffered result together with everything that travels with it.
  typedef struct packed {
    logic [LaneWidth-1:0] result;
    status_t              status;
    logic                 extension_bit;
    TagType               tag;
    AuxType               aux;
  } entry_t;

  entry_t               mem [Depth];
  entry_t               head;
  entry_t               in_entry;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [CntWidth-1:0]  count;
  status_t              sticky;
  logic                 push;
  logic                 pop;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // Ready and valid depend on the registered count only, so there is no
  // combinational path from out_ready_i to in_ready_o; a full buffer
  // refuses a push even when it is being popped in the same cycle.
  assign in_ready_o  = (count < DepthCnt);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign busy_o      = in_busy_i | out_valid_o;

  assign in_entry = '{
    result:        in_result_i,
    status:        in_status_i,
    extension_bit: in_extension_bit_i,
    tag:           in_tag_i,
    aux:           in_aux_i
  };

  assign head            = mem[rd_ptr];
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.extension_bit;
  assign tag_o           = head.tag;
  assign aux_o           = head.aux;
  assign sticky_status_o = sticky;

  // Entry storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointer and occupancy control; flush drops everything at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: clear acts before the popped status is ORed in, and
  // a flush leaves the flags alone unless a clear comes with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky <= '0;
    end else if (flush_i) begin
      if (clear_status_i) begin
        sticky <= '0;
      end
    end else if (clear_status_i) begin
      sticky <= pop ? head.status : '0;
    end else if (pop) begin
      sticky <= merge_status(sticky, head.status);
    end
  end

endmodule
